// File: rtl/mio_bus_responder_pkg.sv
// mio_pkg: shared FSM/region types and peripheral address map for the MIO bus responder.
package mio_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [2:0] {REG_RAM, REG_DISP, REG_GPIO, REG_CNT, REG_NONE} region_t;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RAM_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] DISP_ADDR = 32'hE000_0000;
    localparam logic [31:0] GPIO_ADDR = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;
endpackage

// File: rtl/mio_addr_decode.sv
// mio_addr_decode: maps a CPU byte address to its bus region (word granularity).
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [31:0] addr,
    output region_t     region
);
    logic [31:0] word;
    always_comb begin
        word   = addr & WORD_MASK;
        region = (addr & RAM_MASK) == 32'h0 ? REG_RAM  :
                 word == DISP_ADDR          ? REG_DISP :
                 word == GPIO_ADDR          ? REG_GPIO :
                 word == CNT_ADDR           ? REG_CNT  : REG_NONE;
    end
endmodule

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: completes CPU MIO word requests against block RAM and peripheral registers.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        bus_err,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [31:0] disp_out
);
    state_t      state, next;
    region_t     dec, region;
    logic        we_l, accept, cap;
    logic [3:0]  wcnt;
    logic [31:0] cnt, rdata;

    mio_addr_decode u_dec (.addr(Addr_out), .region(dec));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    always_comb begin
        next   = state;
        accept = state == IDLE && CPU_MIO;
        cap    = state == WAIT && wcnt == 4'd0;
        next   = state == IDLE ? (CPU_MIO ? WAIT : IDLE) :
                 state == WAIT ? (cap ? DONE : WAIT) : IDLE;
        rdata  = region == REG_RAM  ? ram_dout :
                 region == REG_DISP ? disp_out :
                 region == REG_GPIO ? {16'h0, sw_in} :
                 region == REG_CNT  ? cnt : 32'h0;
    end

    // The latched write data lives in ram_din and doubles as peripheral write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region   <= REG_NONE;
            we_l     <= 1'b0;
            wcnt     <= 4'd0;
            ram_addr <= 10'd0;
            ram_din  <= 32'h0;
            Data_in  <= 32'h0;
            led_out  <= 16'h0;
            disp_out <= 32'h0;
            cnt      <= 32'h0;
        end else begin
            cnt <= (cap && we_l && region == REG_CNT) ? ram_din : cnt + 32'd1;
            if (accept) begin
                region   <= dec;
                we_l     <= mem_w;
                ram_addr <= Addr_out[11:2];
                ram_din  <= Data_out;
                wcnt     <= dec == REG_RAM ? 4'(RAM_WAIT) : 4'd0;
            end else if (state == WAIT && !cap) begin
                wcnt <= wcnt - 4'd1;
            end
            if (cap && !we_l) Data_in <= rdata;
            if (cap && we_l && region == REG_DISP) disp_out <= ram_din;
            if (cap && we_l && region == REG_GPIO) led_out <= ram_din[15:0];
        end
    end

    assign MIO_ready = state == DONE;
    assign bus_err   = state == DONE && region == REG_NONE;
    assign ram_we    = state == DONE && we_l && region == REG_RAM;
endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: directed plus randomized transactions checked against a transaction-level model.
module tb_mio_bus_responder;
    localparam int RAM_WAIT = 1;

    logic        clk = 1'b0, rst_n = 1'b0, CPU_MIO = 1'b0, mem_w = 1'b0;
    logic [31:0] Addr_out = '0, Data_out = '0, Data_in, ram_din, disp_out;
    logic [31:0] ram_dout = '0;
    logic        MIO_ready, bus_err, ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] sw_in = '0, led_out;

    mio_bus_responder #(.RAM_WAIT(RAM_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
        .MIO_ready(MIO_ready), .bus_err(bus_err), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .sw_in(sw_in), .led_out(led_out), .disp_out(disp_out)
    );

    always #5 clk = ~clk;

    // external synchronous RAM and edge/pulse bookkeeping
    logic [31:0] mem [1024];
    int          cyc = 0, we_pulses = 0;
    logic [9:0]  we_addr = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        cyc <= cyc + 1;
        if (ram_we) begin
            we_pulses <= we_pulses + 1;
            we_addr   <= ram_addr;
        end
    end

    // reference model state
    logic [31:0] ref_ram [1024];
    logic [31:0] m_disp = '0, m_cnt_base = '0;
    logic [15:0] m_led = '0;
    int          m_cnt_cyc = 0;
    int          checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [31:0] a);
        if (a < 32'h1000) return 0;
        if (a >= 32'hE000_0000 && a <= 32'hE000_0003) return 1;
        if (a >= 32'hF000_0000 && a <= 32'hF000_0003) return 2;
        if (a >= 32'hF000_0004 && a <= 32'hF000_0007) return 3;
        return 4;
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data);
        int r, e0, cap, w0;
        logic [31:0] exp_rd;
        r      = classify(addr);
        w0     = we_pulses;
        cap    = -1;
        exp_rd = 32'h0;
        CPU_MIO = 1'b1; mem_w = we; Addr_out = addr; Data_out = data;
        @(posedge clk); #1;
        e0 = cyc;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (MIO_ready) begin
                cap = cyc;
                break;
            end
        end
        if (cap < 0) begin
            check("ready_timeout", {31'h0, MIO_ready}, 32'h1);
            return;
        end
        check("latency", cap - e0, r == 0 ? RAM_WAIT + 1 : 1);
        check("bus_err", {31'h0, bus_err}, {31'h0, r == 4});
        if (!we) begin
            case (r)
                0: exp_rd = ref_ram[addr[11:2]];
                1: exp_rd = m_disp;
                2: exp_rd = {16'h0, sw_in};
                3: exp_rd = m_cnt_base + 32'(cap - m_cnt_cyc - 1);
                default: exp_rd = 32'h0;
            endcase
            check("rdata", Data_in, exp_rd);
        end else begin
            case (r)
                0: ref_ram[addr[11:2]] = data;
                1: m_disp = data;
                2: m_led = data[15:0];
                3: begin m_cnt_base = data; m_cnt_cyc = cap; end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        check("ready_pulse", {31'h0, MIO_ready}, 32'h0);
        check("ram_we_pulses", we_pulses - w0, (we && r == 0) ? 1 : 0);
        if (we && r == 0) check("ram_we_addr", {22'h0, we_addr}, {22'h0, addr[11:2]});
        if (!we) check("rdata_hold", Data_in, exp_rd);
        check("led", {16'h0, led_out}, {16'h0, m_led});
        check("disp", disp_out, m_disp);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt_base = 32'h0;
        m_cnt_cyc  = cyc;
    endtask

    task automatic idle(input int n);
        CPU_MIO = 1'b0;
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        logic [31:0] a, d;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0;
            ref_ram[i] = 32'h0;
        end
        #12;
        check("rst_ready", {31'h0, MIO_ready}, 32'h0);
        check("rst_data_in", Data_in, 32'h0);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        check("rst_led", {16'h0, led_out}, 32'h0);
        release_reset();

        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        idle(1);
        txn(1'b0, 32'h0000_0010, 32'h0);
        check("ram_read_direct", Data_in, 32'hDEAD_BEEF);
        sw_in = 16'hA5A5;
        txn(1'b0, 32'hF000_0000, 32'h0);
        check("gpio_read_direct", Data_in, 32'h0000_A5A5);
        txn(1'b1, 32'hF000_0000, 32'h1234_5678);
        check("led_direct", {16'h0, led_out}, 32'h0000_5678);
        txn(1'b1, 32'hF000_0004, 32'h100);
        idle(8);
        txn(1'b0, 32'hF000_0004, 32'h0);
        check("cnt_read_direct", Data_in, 32'h100 + 32'd10);
        txn(1'b0, 32'h8000_0000, 32'h0);
        txn(1'b1, 32'h8000_0004, 32'hFFFF_FFFF);
        txn(1'b1, 32'hE000_0000, 32'h0BAD_CAFE);
        txn(1'b0, 32'hF000_0000, 32'h0);
        idle(1);

        // reset during a RAM write's wait state
        w0 = we_pulses;
        CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h0000_0040; Data_out = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_ram_din", ram_din, 32'h0);
        check("arst_ram_addr", {22'h0, ram_addr}, 32'h0);
        check("arst_disp", disp_out, 32'h0);
        check("arst_led", {16'h0, led_out}, 32'h0);
        check("arst_ready", {31'h0, MIO_ready}, 32'h0);
        CPU_MIO = 1'b0;
        m_disp = 32'h0;
        m_led  = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_we", we_pulses - w0, 32'h0);
        release_reset();
        txn(1'b0, 32'h0000_0040, 32'h0);
        txn(1'b0, 32'h0000_0010, 32'h0);

        for (int n = 0; n < 80; n++) begin
            a = $urandom();
            d = $urandom();
            sw_in = 16'($urandom());
            case ($urandom_range(0, 4))
                0: a = a & 32'h0000_0FFF;
                1: a = 32'hE000_0000 | (a & 32'h3);
                2: a = 32'hF000_0000 | (a & 32'h3);
                3: a = 32'hF000_0004 | (a & 32'h3);
                default: a = 32'h8000_0000 | (a & 32'h0FFF_FFFF);
            endcase
            txn(1'($urandom_range(0, 1)), a, d);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
